// File: rtl/rst_cmd_initiator_pkg.sv
// +----------------------------------------------------------------------------+
// | rst_cmd_initiator_pkg                                                      |
// | Shared state encodings, opcodes and width helpers for the cmd sequencer.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package rst_cmd_initiator_pkg;

  localparam int CMD_WIDTH_DEF = 16;
  localparam int CNT_WIDTH     = 8;
  localparam int TIMER_WIDTH   = 8;

  localparam logic [1:0] OP_STP = 2'b00;
  localparam logic [1:0] OP_EVP = 2'b01;
  localparam logic [1:0] OP_EVB = 2'b10;
  localparam logic [1:0] OP_RST = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_RST_REQ  = 3'd3,
    ST_RST_WAIT = 3'd4,
    ST_DISPATCH = 3'd5
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_cmd_initiator_rst_wait_timer.sv
// +----------------------------------------------------------------------------+
// | rst_wait_timer                                                             |
// | Clearable up-counter with terminal-count flag; exists only with            |
// | RST_TIMEOUT_EN defined.                                   Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef RST_TIMEOUT_EN
module rst_wait_timer #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Holds at the terminal value so o_tc stays asserted until cleared.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != TC_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = i_enable && (count_q == TC_VAL);

endmodule
`endif

`default_nettype wire

// File: rtl/rst_cmd_initiator.sv
// +----------------------------------------------------------------------------+
// | rst_cmd_initiator                                                          |
// | Fetches/decodes command words; drives the reset handshake for RST and      |
// | forwards other opcodes. RST_TIMEOUT_EN adds a done_rst timeout. Rev 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rst_cmd_initiator
  import rst_cmd_initiator_pkg::*;
#(
  parameter int buffer_size = 1024,
  parameter int CMD_WIDTH   = CMD_WIDTH_DEF,
  parameter int RST_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_empty,
  output logic                 cmd_rd_en,
  input  logic [CMD_WIDTH-1:0] cmd_data,
  output logic                 start_rst,
  input  logic                 done_rst,
  output logic                 cmd_out_valid,
  input  logic                 cmd_out_ready,
  output logic [CMD_WIDTH-1:0] cmd_out_data,
  output logic                 rst_busy,
  output logic [CNT_WIDTH-1:0] rst_count,
  output logic                 rst_timeout
);

  if ((clog2(buffer_size) < 1) || (CMD_WIDTH < 2) ||
      (RST_TIMEOUT < 2) || (RST_TIMEOUT > (1 << TIMER_WIDTH))) begin : g_bad_cfg
    $error("rst_cmd_initiator: unsupported parameter combination");
  end

  state_e               state_q;
  state_e               state_d;
  logic [CMD_WIDTH-1:0] cmd_reg_q;
  logic [CMD_WIDTH-1:0] cmd_reg_d;
  logic [CNT_WIDTH-1:0] rst_count_q;
  logic [CNT_WIDTH-1:0] rst_count_d;
  logic [1:0]           opcode;

  assign opcode = cmd_data[CMD_WIDTH-1 -: 2];

`ifdef RST_TIMEOUT_EN
  logic rst_timeout_q;
  logic rst_timeout_d;
  logic timer_tc;

  rst_wait_timer #(
    .WIDTH    (TIMER_WIDTH),
    .TERMINAL (RST_TIMEOUT - 1)
  ) u_rst_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (state_q == ST_RST_REQ),
    .i_enable (state_q == ST_RST_WAIT),
    .o_tc     (timer_tc)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cmd_reg_d   = cmd_reg_q;
    rst_count_d = rst_count_q;
`ifdef RST_TIMEOUT_EN
    rst_timeout_d = rst_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        cmd_reg_d = cmd_data;
        case (opcode)
          OP_RST:                 state_d = ST_RST_REQ;
          OP_STP, OP_EVP, OP_EVB: state_d = ST_DISPATCH;
          default:                state_d = ST_DISPATCH;
        endcase
      end
      ST_RST_REQ: begin
        state_d = ST_RST_WAIT;
      end
      ST_RST_WAIT: begin
        // A done_rst arriving on the terminal cycle still counts as completion.
        if (done_rst) begin
          state_d     = ST_IDLE;
          rst_count_d = rst_count_q + 1'b1;
        end
`ifdef RST_TIMEOUT_EN
        else if (timer_tc) begin
          state_d       = ST_IDLE;
          rst_timeout_d = 1'b1;
        end
`endif
      end
      ST_DISPATCH: begin
        if (cmd_out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_reg_q   <= '0;
      rst_count_q <= '0;
`ifdef RST_TIMEOUT_EN
      rst_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_reg_q   <= cmd_reg_d;
      rst_count_q <= rst_count_d;
`ifdef RST_TIMEOUT_EN
      rst_timeout_q <= rst_timeout_d;
`endif
    end
  end

  assign cmd_rd_en     = (state_q == ST_FETCH);
  assign start_rst     = (state_q == ST_RST_REQ);
  assign cmd_out_valid = (state_q == ST_DISPATCH);
  assign cmd_out_data  = cmd_reg_q;
  assign rst_busy      = (state_q == ST_RST_REQ) || (state_q == ST_RST_WAIT);
  assign rst_count     = rst_count_q;
`ifdef RST_TIMEOUT_EN
  assign rst_timeout   = rst_timeout_q;
`else
  assign rst_timeout   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_cmd_initiator.sv
// +----------------------------------------------------------------------------+
// | tb_rst_cmd_initiator                                                       |
// | Directed table-driven bench with command-FIFO and reset-FSM models.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rst_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_empty;
  logic        cmd_rd_en;
  logic [15:0] cmd_data;
  logic        start_rst;
  logic        done_rst;
  logic        cmd_out_valid;
  logic        cmd_out_ready;
  logic [15:0] cmd_out_data;
  logic        rst_busy;
  logic [7:0]  rst_count;
  logic        rst_timeout;

  always #5 clk = ~clk;

  rst_cmd_initiator dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_empty     (cmd_empty),
    .cmd_rd_en     (cmd_rd_en),
    .cmd_data      (cmd_data),
    .start_rst     (start_rst),
    .done_rst      (done_rst),
    .cmd_out_valid (cmd_out_valid),
    .cmd_out_ready (cmd_out_ready),
    .cmd_out_data  (cmd_out_data),
    .rst_busy      (rst_busy),
    .rst_count     (rst_count),
    .rst_timeout   (rst_timeout)
  );

  typedef struct {
    logic [15:0] word;
    int          ready_delay;
    int          done_delay;
    int          exp_start;
    int          exp_busy;
    int          exp_valid;
    int          exp_cnt;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] fifo[$];
  int          pending;
  int          reply_delay;
  int          n_vec;
  int          n_bad;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: FIFO pops on a sampled read strobe, reset FSM replies reply_delay cycles after start_rst.
  task automatic step();
    logic rd_pre;
    logic start_pre;
    rd_pre    = cmd_rd_en;
    start_pre = start_rst;
    @(posedge clk);
    #1;
    if (rd_pre && fifo.size() > 0) cmd_data = fifo.pop_front();
    cmd_empty = (fifo.size() == 0);
    done_rst  = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) done_rst = 1'b1;
    end
    if (start_pre && reply_delay > 0) begin
      if (reply_delay == 1) done_rst = 1'b1;
      else pending = reply_delay - 1;
    end
  endtask

  task automatic do_reset(input string tag);
    fifo.delete();
    cmd_empty   = 1'b1;
    reply_delay = 0;
    pending     = 0;
    done_rst    = 1'b0;
    rst         = 1'b1;
    step();
    rst         = 1'b0;
    chk({tag, "_rd_en"},     cmd_rd_en,     0);
    chk({tag, "_start_rst"}, start_rst,     0);
    chk({tag, "_valid"},     cmd_out_valid, 0);
    chk({tag, "_data"},      cmd_out_data,  0);
    chk({tag, "_busy"},      rst_busy,      0);
    chk({tag, "_count"},     rst_count,     0);
    chk({tag, "_timeout"},   rst_timeout,   0);
  endtask

  task automatic run_vec(input vec_t v);
    int nrd, nstart, nbusy, nvalid, bad_data, first_rd, first_act, win;
    nrd = 0; nstart = 0; nbusy = 0; nvalid = 0; bad_data = 0;
    first_rd = -1; first_act = -1;
    fifo.push_back(v.word);
    cmd_empty     = 1'b0;
    reply_delay   = v.done_delay;
    cmd_out_ready = 1'b1;
    win = 8 + v.ready_delay + v.done_delay;
    for (int k = 1; k <= win; k++) begin
      step();
      if (cmd_rd_en) begin
        nrd++;
        if (first_rd < 0) first_rd = k;
      end
      if (start_rst) begin
        nstart++;
        if (first_act < 0) first_act = k;
      end
      if (rst_busy) nbusy++;
      if (cmd_out_valid) begin
        nvalid++;
        if (first_act < 0) first_act = k;
        if (cmd_out_data !== v.word) bad_data++;
      end
      cmd_out_ready = !cmd_out_valid || (nvalid > v.ready_delay);
    end
    chk("rd_en_pulses",  nrd,       1);
    chk("rd_en_latency", first_rd,  1);
    chk("start_pulses",  nstart,    v.exp_start);
    chk("busy_cycles",   nbusy,     v.exp_busy);
    chk("valid_cycles",  nvalid,    v.exp_valid);
    chk("first_action",  first_act, 3);
    chk("data_unstable", bad_data,  0);
    chk("rst_count",     rst_count, v.exp_cnt);
    chk("idle_at_end",   {rst_busy, cmd_out_valid}, 0);
  endtask

  initial begin
    int   nrd, nvalid, nbusy, nwait, seen, v1k, v2k;
    vec_t vx;
    n_vec = 0; n_bad = 0; pending = 0; reply_delay = 0;
    rst = 1'b1; cmd_empty = 1'b1; cmd_data = '0; done_rst = 1'b0; cmd_out_ready = 1'b0;

    //            word    rdy dly st busy val cnt
    vecs[0] = '{16'h1234,  0, 0, 0, 0,  1, 0};
    vecs[1] = '{16'h5A5A, 10, 0, 0, 0, 11, 0};
    vecs[2] = '{16'hC000,  0, 2, 1, 3,  0, 1};
    vecs[3] = '{16'h4321,  2, 0, 0, 0,  3, 1};
    vecs[4] = '{16'h8ABC,  0, 0, 0, 0,  1, 1};
    vecs[5] = '{16'hFFFF,  0, 5, 1, 6,  0, 2};
    vecs[6] = '{16'h3FFF,  0, 0, 0, 0,  1, 2};
    vecs[7] = '{16'hBFFF,  1, 0, 0, 0,  2, 2};
    vecs[8] = '{16'hC001,  0, 1, 1, 2,  0, 3};

    // Reset held two cycles, then an empty FIFO must never be read.
    step();
    do_reset("por");
    nrd = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (cmd_rd_en) nrd++;
    end
    chk("empty_no_read", nrd, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back words: one command per four cycles.
    fifo.push_back(16'h1111);
    fifo.push_back(16'h2222);
    cmd_empty = 1'b0; cmd_out_ready = 1'b1; v1k = -1; v2k = -1; nvalid = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (cmd_out_valid) begin
        nvalid++;
        if (cmd_out_data == 16'h1111) v1k = k;
        if (cmd_out_data == 16'h2222) v2k = k;
      end
    end
    chk("b2b_valid_cycles", nvalid, 2);
    chk("b2b_first_at",     v1k,    3);
    chk("b2b_second_at",    v2k,    7);

    // rst_count wrap over 256 RST commands.
    do_reset("pre_wrap");
    nvalid = 0; nbusy = 0;
    for (int n = 1; n <= 256; n++) begin
      fifo.push_back(16'hC000);
      cmd_empty = 1'b0; reply_delay = 2;
      for (int k = 1; k <= 6; k++) begin
        step();
        if (cmd_out_valid) nvalid++;
        if (rst_busy) nbusy++;
      end
      if (n == 255) chk("count_at_255", rst_count, 255);
    end
    chk("count_wrapped", rst_count, 0);
    chk("wrap_no_valid", nvalid,    0);
    chk("wrap_busy_cyc", nbusy,     768);

    vx = '{16'hC000, 0, 2, 1, 3, 0, 1};
    run_vec(vx);

    // RST with no reply from the reset FSM.
    fifo.push_back(16'hC000);
    cmd_empty = 1'b0; reply_delay = 0; nwait = 0; seen = 0;
    for (int k = 1; k <= 100 && seen == 0; k++) begin
      step();
      if (rst_busy && !start_rst) nwait++;
      if (rst_timeout) seen = 1;
    end
`ifdef RST_TIMEOUT_EN
    chk("timeout_seen",   seen,      1);
    chk("timeout_waits",  nwait,     64);
    chk("timeout_idle",   rst_busy,  0);
    chk("timeout_count",  rst_count, 1);
    done_rst = 1'b1;
    step();
    step();
    chk("spurious_count", rst_count,   1);
    chk("timeout_sticky", rst_timeout, 1);
`else
    chk("no_timeout",     seen,      0);
    chk("still_waiting",  rst_busy,  1);
    chk("wait_cycles",    nwait,     97);
    chk("hang_count",     rst_count, 1);
`endif
    do_reset("after_hang");

    // Reset in RST_WAIT, then reset in DISPATCH.
    fifo.push_back(16'hC000);
    cmd_empty = 1'b0; reply_delay = 0;
    for (int k = 0; k < 5; k++) step();
    chk("in_rst_wait", {rst_busy, start_rst}, 2'b10);
    do_reset("rst_in_wait");
    fifo.push_back(16'h5A5A);
    cmd_empty = 1'b0; cmd_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("in_dispatch", cmd_out_valid, 1);
    do_reset("rst_in_dispatch");
    vx = '{16'h0001, 0, 0, 0, 0, 1, 0};
    run_vec(vx);

    // done_rst while idle is ignored.
    done_rst = 1'b1;
    step();
    step();
    step();
    chk("idle_done_count", rst_count, 0);
    chk("idle_done_busy",  rst_busy,  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rst_cmd_initiator.md
# rst_cmd_initiator

Front-end command sequencer for the polynomial evaluation accelerator. It fetches command words from the command FIFO and decodes the opcode. RST commands drive the start_rst/done_rst handshake of the reset FSM, which zeroes the command/data read addresses. All other commands go to the downstream evaluator over a valid/ready port. It is the requesting end of the reset handshake.

## Interface
- buffer_size, 1024, depth of command/data FIFOs (kept for address-width consistency with the reset FSM)
- CMD_WIDTH, 16, command word width
- RST_TIMEOUT, 64, max cycles to wait for done_rst (used only with RST_TIMEOUT_EN)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_empty  in  1  command FIFO empty
- cmd_rd_en  out  1  command FIFO read strobe; data valid one cycle later
- cmd_data  in  CMD_WIDTH  command FIFO read data; opcode = cmd_data[15:14]
- start_rst  out  1  reset request to reset FSM, one-cycle pulse
- done_rst  in  1  reset completion from reset FSM, one-cycle pulse
- cmd_out_valid  out  1  non-RST command available
- cmd_out_ready  in  1  downstream accepts command
- cmd_out_data  out  CMD_WIDTH  latched command word
- rst_busy  out  1  high from RST_REQ through RST_WAIT
- rst_count  out  8  completed RST commands, wraps 255->0
- rst_timeout  out  1  sticky: done_rst never arrived

## Operation
- Moore FSM, one-hot-free 3-bit binary encoding. States: IDLE, FETCH, DECODE, RST_REQ, RST_WAIT, DISPATCH.
- IDLE: if !cmd_empty -> FETCH, else stay.
- FETCH: cmd_rd_en=1 for exactly this cycle -> DECODE.
- DECODE: latch cmd_data into cmd_reg. Opcode 2'b11 -> RST_REQ; any other opcode -> DISPATCH.
- RST_REQ: start_rst=1 for exactly this cycle -> RST_WAIT.
- RST_WAIT: on done_rst -> IDLE and rst_count+1. cmd_reg is not forwarded.
- DISPATCH: cmd_out_valid=1 and cmd_out_data=cmd_reg, held stable. On cmd_out_valid && cmd_out_ready -> IDLE.
- Only one command is in flight. There is no prefetch, so the reset FSM's read-address zeroing never invalidates a buffered word.
- done_rst outside RST_WAIT is ignored. cmd_out_ready outside DISPATCH is ignored.

## Timing
- Reset values: state=IDLE, cmd_rd_en=0, start_rst=0, cmd_out_valid=0, cmd_out_data=0, rst_busy=0, rst_count=0, rst_timeout=0, cmd_reg=0, timer=0.
- Outputs are decoded from the registered state, so there is no combinational path from inputs to outputs.
- Non-RST latency: cmd_empty low at edge N -> cmd_rd_en at N+1 -> cmd_out_valid from N+3. Best-case throughput is one command per 4 cycles.
- RST latency: start_rst at N+3. The reset FSM answers with done_rst two cycles later (N+5). The block is back in IDLE at N+6.
- rst asserted in any state: IDLE on the next edge. The in-flight command is dropped. start_rst and cmd_out_valid are low after that edge.
- rst_count increments on the done_rst edge only.

## Configuration
- RST_TIMEOUT_EN defined: an 8-bit timer clears on entry to RST_WAIT and increments each cycle there.
- If the timer reaches RST_TIMEOUT-1 without done_rst: rst_timeout<=1, state -> IDLE, rst_count unchanged.
- If done_rst and timeout occur in the same cycle, done_rst wins.
- RST_TIMEOUT_EN undefined: RST_WAIT waits indefinitely, rst_timeout is tied 0, and no timer logic is built.

## Structure
- Shared package holds the state encodings, opcode constants (OP_RST=2'b11, OP_STP, OP_EVP, OP_EVB), CMD_WIDTH and the log2 function.
- One sub-module, rst_wait_timer: clear, enable, terminal-count output. It is instantiated only under RST_TIMEOUT_EN.

## Test plan
- Reset: hold rst 2 cycles -> all outputs 0, state IDLE; cmd_empty=1 for 20 cycles -> no cmd_rd_en.
- Dispatch: FIFO holds 16'h1234, cmd_out_ready=1 -> one cmd_rd_en pulse, cmd_out_data=16'h1234 with valid for 1 cycle, start_rst never asserted.
- Backpressure: word 16'h5A5A, cmd_out_ready=0 for 10 cycles -> valid and data held stable for 10 cycles, no further cmd_rd_en; ready=1 -> accepted, back to IDLE.
- RST handshake: word 16'hC000 with a reset-FSM model replying 2 cycles later -> start_rst pulses 1 cycle, rst_busy high 3 cycles, rst_count=1, cmd_out_valid never high. Repeat 256 times -> rst_count wraps to 0.
- Timeout (RST_TIMEOUT_EN, RST_TIMEOUT=64): word 16'hC000, done_rst held 0 -> rst_timeout=1 after 64 RST_WAIT cycles, IDLE, rst_count unchanged. Spurious done_rst later -> ignored.
- Mid-operation reset: rst asserted in RST_WAIT and again in DISPATCH -> next edge IDLE, start_rst=0, cmd_out_valid=0. A following 16'h0001 dispatches normally.
